mult_sequencer: RTL and testbench

//  Sequences a multi-cycle radix-2 shift-add multiplier for the DLX EX stage.
//  - Accepts a multiply issued by the control unit (Mult opcode, ALUOp = funct).
//  - Stalls the pipeline while the multiply iterates.
//  - Returns the low product word to the EX-stage result mux.
//  - Aborts cleanly when the control unit raises EXflush.

---
 rtl/mult_sequencer.sv | 163 ++++++++++++++++
 tb/tb_mult_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Sequencer for a multi-cycle radix-2 shift-add multiplier in the DLX EX stage.
// Define MULT_SEQ_HI_EN to add the result_hi port carrying the upper product word.
module mult_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef MULT_SEQ_HI_EN
    ,
    output logic [WIDTH-1:0] result_hi
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [WIDTH:0]     partialSum;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH-1:0]   lowFixed;
    logic               accept;

`ifdef MULT_SEQ_HI_EN
    logic [2*WIDTH-1:0] fullFixed;
    logic [WIDTH-1:0]   hiFixed;
    logic [WIDTH-1:0]   resultHi_q, resultHi_d;

    // The sign fix negates the whole double-width product so the upper word stays consistent.
    always_comb begin
        fullFixed = sign_q ? (~acc_q + 1'b1) : acc_q;
        lowFixed  = fullFixed[WIDTH-1:0];
        hiFixed   = fullFixed[2*WIDTH-1:WIDTH];
    end
`else
    always_comb begin
        lowFixed = sign_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    end
`endif

    // The most negative operand maps onto itself, which is exactly its unsigned magnitude.
    always_comb begin
        absA   = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
        absB   = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
        accept = start && !flush && (state_q == IDLE || state_q == DONE);
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        sign_d     = sign_q;
        result_d   = result_q;
`ifdef MULT_SEQ_HI_EN
        resultHi_d = resultHi_q;
`endif
        stall      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        partialSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (mplier_q[0] ? {1'b0, mcand_q} : '0);

        case (state_q)
            IDLE: begin
                stall = start && !flush;
            end
            RUN: begin
                stall    = 1'b1;
                busy     = 1'b1;
                acc_d    = {partialSum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    done       = 1'b1;
                    result_d   = lowFixed;
`ifdef MULT_SEQ_HI_EN
                    resultHi_d = hiFixed;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            mcand_d  = signed_op ? absA : op_a;
            mplier_d = signed_op ? absB : op_b;
            sign_d   = signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc_d    = '0;
            count_d  = '0;
            state_d  = RUN;
        end

        // A flush overrides everything, including a start that arrives in the same cycle.
        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            sign_q     <= 1'b0;
            result_q   <= '0;
`ifdef MULT_SEQ_HI_EN
            resultHi_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            sign_q     <= sign_d;
            result_q   <= result_d;
`ifdef MULT_SEQ_HI_EN
            resultHi_q <= resultHi_d;
`endif
        end
    end

    // The result is presented in the done cycle itself and held in result_q afterwards.
    always_comb begin
        result    = done ? lowFixed : result_q;
`ifdef MULT_SEQ_HI_EN
        result_hi = done ? hiFixed : resultHi_q;
`endif
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed and random multiplies
// compared against a plain-arithmetic product model.
module tb_mult_sequencer;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             signedOp;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
`ifdef MULT_SEQ_HI_EN
    logic [WIDTH-1:0] resultHi;
`endif

    int checkCount = 0;
    int errorCount = 0;

    mult_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .signed_op(signedOp),
        .op_a     (opA),
        .op_b     (opB),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result)
`ifdef MULT_SEQ_HI_EN
        ,
        .result_hi(resultHi)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Reference product straight from integer arithmetic on the operands.
    function automatic logic [63:0] refProduct(input logic sg, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = 64'(a);
        ub = 64'(b);
        return ua * ub;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic sg, input logic [31:0] a,
                                 input logic [31:0] b, input logic f);
        start    = s;
        signedOp = sg;
        opA      = a;
        opB      = b;
        flush    = f;
        #1;
    endtask

    // Issues one multiply at the current cycle and leaves the bench in its done cycle.
    task automatic runOp(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic fromDone);
        logic [63:0] expected;
        int          runBad;
        expected = refProduct(sg, a, b);
        applyStimulus(1'b1, sg, a, b, 1'b0);
        checkOutput({tag, ".issueStall"}, 64'(stall), fromDone ? 64'd0 : 64'd1);
        runBad = 0;
        for (int c = 1; c <= WIDTH; c++) begin
            nextCycle();
            applyStimulus(c < WIDTH, 1'($urandom), $urandom, $urandom, 1'b0);
            if ({busy, stall, done} !== 3'b110) runBad++;
        end
        checkOutput({tag, ".runShape"}, 64'(runBad), 64'd0);
        nextCycle();
        checkOutput({tag, ".done"}, 64'({busy, stall, done}), 64'b001);
        checkOutput({tag, ".result"}, 64'(result), 64'(expected[31:0]));
`ifdef MULT_SEQ_HI_EN
        checkOutput({tag, ".resultHi"}, 64'(resultHi), 64'(expected[63:32]));
`endif
    endtask

    task automatic checkHeld(input string tag, input logic [31:0] expectedLow);
        checkOutput({tag, ".donePulse"}, 64'(done), 64'd0);
        checkOutput({tag, ".held"}, 64'(result), 64'(expectedLow));
    endtask

    initial begin
        logic [63:0] prod;
        logic [31:0] ra, rb;
        logic        rs;
        logic        chain;
        int          doneSeen;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        repeat (3) nextCycle();
        checkOutput("reset.flags", 64'({stall, busy, done}), 64'd0);
        checkOutput("reset.result", 64'(result), 64'd0);
`ifdef MULT_SEQ_HI_EN
        checkOutput("reset.resultHi", 64'(resultHi), 64'd0);
`endif
        rst = 1'b0;
        nextCycle();

        runOp("unsigned7x6", 1'b0, 32'd7, 32'd6, 1'b0);
        nextCycle();
        checkHeld("unsigned7x6", 32'd42);

        runOp("signedNeg3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        nextCycle();
        checkHeld("signedNeg3x5", 32'hFFFF_FFF1);

        runOp("maxUnsigned", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runOp("backToBack2x3", 1'b0, 32'd2, 32'd3, 1'b1);
        nextCycle();
        checkHeld("backToBack2x3", 32'd6);

        applyStimulus(1'b1, 1'b0, $urandom, $urandom, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("flush.flags", 64'({stall, busy, done}), 64'd0);
        checkOutput("flush.result", 64'(result), 64'd6);
        applyStimulus(1'b1, 1'b0, 32'd9, 32'd9, 1'b1);
        checkOutput("flushBeatsStart.stall", 64'(stall), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        doneSeen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) doneSeen++;
            nextCycle();
        end
        checkOutput("flush.noDone", 64'(doneSeen), 64'd0);
        checkOutput("flush.resultKept", 64'(result), 64'd6);

        runOp("minNegSquared", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        runOp("minNegTimesNeg1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        nextCycle();

        chain = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            prod = refProduct(rs, ra, rb);
            runOp($sformatf("random%0d", i), rs, ra, rb, chain);
            chain = 1'($urandom);
            if (!chain) begin
                nextCycle();
                checkHeld($sformatf("random%0d", i), prod[31:0]);
            end
        end
        if (chain) nextCycle();

        applyStimulus(1'b1, 1'b1, $urandom, $urandom, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        end
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("midRunReset.flags", 64'({stall, busy, done}), 64'd0);
        checkOutput("midRunReset.result", 64'(result), 64'd0);
`ifdef MULT_SEQ_HI_EN
        checkOutput("midRunReset.resultHi", 64'(resultHi), 64'd0);
`endif
        runOp("afterReset7x6", 1'b0, 32'd7, 32'd6, 1'b0);
        nextCycle();
        checkHeld("afterReset7x6", 32'd42);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
